// File: rtl/tile_mem_pkg.sv
// tile_mem_pkg: state encoding and linear-index helper
// shared by the tile_mem_2d sources.
package tile_mem_pkg;

   typedef enum logic [1:0] {
      CLEAR,
      IDLE,
      FILL
   } tm_state_e;

   function automatic int unsigned lin_idx(
      input int unsigned row,
      input int unsigned col,
      input int unsigned cols
   );
      return row * cols + col;
   endfunction

endpackage

// File: rtl/tile_mem_2d_array.sv
// tile_mem_2d_array: 1W/1R storage, registered read,
// read-first on a same-entry collision. No reset on contents.
module tile_mem_2d_array #(
   parameter int W     = 8,
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [W-1:0]  i_wdata,
   input  logic          i_re,
   input  logic [AW-1:0] i_raddr,
   output logic [W-1:0]  o_rdata
);

   logic [W-1:0] r_mem [DEPTH];
   logic [W-1:0] r_q;

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      if (i_re) r_q <= r_mem[i_raddr];
   end

   assign o_rdata = r_q;

endmodule

// File: rtl/tile_mem_2d.sv
// tile_mem_2d: 2-D tile store with auto-clear and range fill.
// Define TILE_MEM_2D_PARITY_EN to keep an even-parity bit per entry.
module tile_mem_2d
   import tile_mem_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ROWS   = 16,
   parameter int COLS   = 16,
   parameter logic [DATA_W-1:0] INIT_VAL = '0,
   localparam int RW = $clog2(ROWS),
   localparam int CW = $clog2(COLS),
   localparam int N  = ROWS * COLS,
   localparam int IW = $clog2(N)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [RW-1:0]     wr_row,
   input  logic [CW-1:0]     wr_col,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [RW-1:0]     rd_row,
   input  logic [CW-1:0]     rd_col,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   input  logic              fill_req,
   input  logic [IW-1:0]     fill_first,
   input  logic [IW-1:0]     fill_last,
   input  logic [DATA_W-1:0] fill_data,
   output logic              busy,
   output logic              addr_err,
   output logic              rd_perr
);

`ifdef TILE_MEM_2D_PARITY_EN
   localparam int MW = DATA_W + 1;
`else
   localparam int MW = DATA_W;
`endif
   localparam logic [RW:0] ROWS_L = (RW+1)'(ROWS);
   localparam logic [CW:0] COLS_L = (CW+1)'(COLS);
   localparam logic [IW:0] N_L    = (IW+1)'(N);

   tm_state_e         r_state;
   logic [IW-1:0]     r_idx;
   logic [IW-1:0]     r_last;
   logic              r_down;
   logic              r_busy;
   logic [DATA_W-1:0] r_fdata;
   logic              r_rd_valid;
   logic              r_rd_zero;
   logic              r_addr_err;

   logic              w_rd_oob;
   logic              w_wr_oob;
   logic              w_fill_oob;
   logic              w_idle;
   logic              w_wr_go;
   logic              w_fill_go;
   logic              w_we;
   logic [IW-1:0]     w_waddr;
   logic [IW-1:0]     w_raddr;
   logic [DATA_W-1:0] w_wdata;
   logic [MW-1:0]     w_wword;
   logic [MW-1:0]     w_rword;

   assign w_rd_oob = ({1'b0, rd_row} >= ROWS_L)
                  || ({1'b0, rd_col} >= COLS_L);
   assign w_wr_oob = ({1'b0, wr_row} >= ROWS_L)
                  || ({1'b0, wr_col} >= COLS_L);
   assign w_fill_oob = ({1'b0, fill_first} >= N_L)
                    || ({1'b0, fill_last} >= N_L);

   assign w_idle    = (r_state == IDLE);
   assign w_wr_go   = w_idle && wr_en && !w_wr_oob;
   assign w_fill_go = w_idle && fill_req && !w_fill_oob;

   assign w_raddr = w_rd_oob ? '0 :
      IW'(lin_idx(32'(rd_row), 32'(rd_col), COLS));

   always_comb begin
      w_we    = w_wr_go;
      w_waddr = IW'(lin_idx(32'(wr_row), 32'(wr_col), COLS));
      w_wdata = wr_data;
      unique case (r_state)
         CLEAR: begin
            w_we    = r_busy;
            w_waddr = r_idx;
            w_wdata = INIT_VAL;
         end
         FILL: begin
            w_we    = 1'b1;
            w_waddr = r_idx;
            w_wdata = r_fdata;
         end
         default: ;
      endcase
   end

`ifdef TILE_MEM_2D_PARITY_EN
   assign w_wword = {^w_wdata, w_wdata};
`else
   assign w_wword = w_wdata;
`endif

   tile_mem_2d_array #(
      .W     (MW),
      .DEPTH (N)
   ) u_arr (
      .clk     (clk),
      .i_we    (w_we && rst_n),
      .i_waddr (w_waddr),
      .i_wdata (w_wword),
      .i_re    (rd_en),
      .i_raddr (w_raddr),
      .o_rdata (w_rword)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= CLEAR;
         r_idx      <= '0;
         r_last     <= '0;
         r_down     <= 1'b0;
         r_busy     <= 1'b0;
         r_fdata    <= '0;
         r_rd_valid <= 1'b0;
         r_rd_zero  <= 1'b1;
         r_addr_err <= 1'b0;
      end else begin
         r_rd_valid <= rd_en;
         if (rd_en) r_rd_zero <= w_rd_oob;
         r_addr_err <= (rd_en && w_rd_oob)
                    || (w_idle && wr_en && w_wr_oob)
                    || (w_idle && fill_req && w_fill_oob);
         unique case (r_state)
            CLEAR: begin
               // first released edge only arms busy; writes follow
               if (!r_busy) begin
                  r_busy <= 1'b1;
               end else if (r_idx == IW'(N - 1)) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            IDLE: begin
               if (w_fill_go) begin
                  r_state <= FILL;
                  r_busy  <= 1'b1;
                  r_idx   <= fill_first;
                  r_last  <= fill_last;
                  r_down  <= (fill_first > fill_last);
                  r_fdata <= fill_data;
               end
            end
            FILL: begin
               if (r_idx == r_last) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end else if (r_down) begin
                  r_idx <= r_idx - 1'b1;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            default: r_state <= CLEAR;
         endcase
      end
   end

   assign rd_data  = r_rd_zero ? '0 : w_rword[DATA_W-1:0];
   assign rd_valid = r_rd_valid;
   assign busy     = r_busy;
   assign addr_err = r_addr_err;

`ifdef TILE_MEM_2D_PARITY_EN
   assign rd_perr = r_rd_valid && !r_rd_zero && (^w_rword);
`else
   assign rd_perr = 1'b0;
`endif

endmodule

// File: tb/tb_tile_mem_2d.sv
// tb_tile_mem_2d: queue-based reference model for a 12x16 instance
// plus directed checks on a default 16x16 instance.
module tb_tile_mem_2d;

   localparam int R = 12;
   localparam int C = 16;
   localparam int N = R * C;
   localparam logic [7:0] IV = 8'h5A;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n = 1'b0;
   logic       wr_en = 1'b0, rd_en = 1'b0, fill_req = 1'b0;
   logic [3:0] wr_row = '0, wr_col = '0;
   logic [3:0] rd_row = '0, rd_col = '0;
   logic [7:0] wr_data = '0, fill_data = '0;
   logic [7:0] fill_first = '0, fill_last = '0;
   logic [7:0] rd_data;
   logic       rd_valid, busy, addr_err, rd_perr;

   logic       rst2_n = 1'b0;
   logic       wr2_en = 1'b0, rd2_en = 1'b0, fill2_req = 1'b0;
   logic [3:0] wr2_row = '0, wr2_col = '0;
   logic [3:0] rd2_row = '0, rd2_col = '0;
   logic [7:0] wr2_data = '0, fill2_data = '0;
   logic [7:0] fill2_first = '0, fill2_last = '0;
   logic [7:0] rd_data2;
   logic       rd_valid2, busy2, addr_err2, rd_perr2;

   tile_mem_2d #(
      .DATA_W(8), .ROWS(R), .COLS(C), .INIT_VAL(IV)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
      .wr_data(wr_data),
      .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col),
      .rd_data(rd_data), .rd_valid(rd_valid),
      .fill_req(fill_req), .fill_first(fill_first),
      .fill_last(fill_last), .fill_data(fill_data),
      .busy(busy), .addr_err(addr_err), .rd_perr(rd_perr)
   );

   tile_mem_2d dut2 (
      .clk(clk), .rst_n(rst2_n),
      .wr_en(wr2_en), .wr_row(wr2_row), .wr_col(wr2_col),
      .wr_data(wr2_data),
      .rd_en(rd2_en), .rd_row(rd2_row), .rd_col(rd2_col),
      .rd_data(rd_data2), .rd_valid(rd_valid2),
      .fill_req(fill2_req), .fill_first(fill2_first),
      .fill_last(fill2_last), .fill_data(fill2_data),
      .busy(busy2), .addr_err(addr_err2), .rd_perr(rd_perr2)
   );

   int n_vec = 0;
   int n_bad = 0;
   bit chk_on = 1'b0;

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] want);
      n_vec++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, want);
      end
   endtask

   // reference model: pending writes of a clear/fill as a queue
   typedef struct packed {
      logic [31:0] idx;
      logic [7:0]  v;
   } wop_t;

   logic [7:0] m [N];
   wop_t       pq[$];
   bit         m_rst  = 1'b1;
   logic       m_busy = 1'b0;
   logic       m_rdv  = 1'b0;
   logic       m_err  = 1'b0;
   logic [7:0] m_rdd  = '0;

   always @(posedge clk) begin : model
      bit   e;
      wop_t w;
      int   f, l;
      e = 1'b0;
      if (!rst_n) begin
         pq.delete();
         m_rst  = 1'b1;
         m_busy = 1'b0;
         m_rdv  = 1'b0;
         m_rdd  = '0;
      end else begin
         m_rdv = rd_en;
         if (rd_en) begin
            if (int'(rd_row) >= R) begin
               m_rdd = '0;
               e = 1'b1;
            end else begin
               m_rdd = m[int'(rd_row) * C + int'(rd_col)];
            end
         end
         if (m_rst) begin
            m_rst  = 1'b0;
            m_busy = 1'b1;
            for (int i = 0; i < N; i++) begin
               w.idx = i;
               w.v   = IV;
               pq.push_back(w);
            end
         end else if (pq.size() != 0) begin
            w = pq.pop_front();
            m[w.idx] = w.v;
            if (pq.size() == 0) m_busy = 1'b0;
         end else begin
            if (wr_en) begin
               if (int'(wr_row) >= R) e = 1'b1;
               else m[int'(wr_row) * C + int'(wr_col)] = wr_data;
            end
            if (fill_req) begin
               f = int'(fill_first);
               l = int'(fill_last);
               if (f >= N || l >= N) begin
                  e = 1'b1;
               end else begin
                  w.v = fill_data;
                  if (f <= l) begin
                     for (int i = f; i <= l; i++) begin
                        w.idx = i;
                        pq.push_back(w);
                     end
                  end else begin
                     for (int i = f; i >= l; i--) begin
                        w.idx = i;
                        pq.push_back(w);
                     end
                  end
                  m_busy = 1'b1;
               end
            end
         end
      end
      m_err = e;
   end

   always @(negedge clk) begin
      if (chk_on) begin
         chk("busy", busy, m_busy);
         chk("rd_valid", rd_valid, m_rdv);
         chk("rd_data", rd_data, m_rdd);
         chk("addr_err", addr_err, m_err);
         chk("rd_perr", rd_perr, 1'b0);
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic clr_in();
      wr_en = 1'b0;
      rd_en = 1'b0;
      fill_req = 1'b0;
   endtask

   task automatic rd(input int r, input int c);
      rd_en = 1'b1;
      rd_row = 4'(r);
      rd_col = 4'(c);
   endtask

   task automatic wr(input int r, input int c,
                     input logic [7:0] d);
      wr_en = 1'b1;
      wr_row = 4'(r);
      wr_col = 4'(c);
      wr_data = d;
   endtask

   task automatic busy_len(input bit sel, output int n);
      n = 0;
      for (int k = 0; k < 400; k++) begin
         tick();
         if (sel ? busy2 : busy) n++;
         else if (n > 0) break;
      end
   endtask

   initial begin : main
      int n, ff, sp, lf;
      logic [7:0] ex5 [5];
      ex5 = '{8'h11, 8'hA5, 8'hA5, 8'hA5, 8'h44};
      tick();
      tick();
      chk_on = 1'b1;

      // default instance: clear length, abort mid-fill
      rst2_n = 1'b1;
      busy_len(1'b1, n);
      chk("d2_clr_len", n, 256);
      rd2_en = 1'b1; rd2_row = 4'd15; rd2_col = 4'd15;
      tick();
      rd2_en = 1'b0;
      chk("d2_rv", rd_valid2, 1'b1);
      chk("d2_rd1515", rd_data2, 8'h00);
      fill2_req = 1'b1; fill2_first = 8'd0;
      fill2_last = 8'd200; fill2_data = 8'h77;
      tick();
      fill2_req = 1'b0;
      repeat (50) tick();
      chk("d2_midfill", busy2, 1'b1);
      rst2_n = 1'b0;
      tick();
      tick();
      chk("d2_rst_busy", busy2, 1'b0);
      chk("d2_rst_rd", rd_data2, 8'h00);
      rst2_n = 1'b1;
      busy_len(1'b1, n);
      chk("d2_reclr_len", n, 256);
      for (int i = 0; i < 256; i++) begin
         rd2_en = 1'b1;
         rd2_row = 4'(i / 16);
         rd2_col = 4'(i % 16);
         tick();
         chk($sformatf("d2_entry%0d", i), rd_data2, 8'h00);
      end
      rd2_en = 1'b0;

      // 12x16 instance
      rst_n = 1'b1;
      busy_len(1'b0, n);
      chk("clr_len", n, N);

      wr(2, 5, 8'h3C);
      rd(2, 5);
      tick();
      clr_in();
      chk("rfirst_v", rd_valid, 1'b1);
      chk("rfirst_d", rd_data, IV);
      rd(2, 5);
      tick();
      clr_in();
      chk("rafter_d", rd_data, 8'h3C);
      tick();
      chk("rv_drop", rd_valid, 1'b0);
      chk("rd_hold", rd_data, 8'h3C);

      wr(0, 0, 8'h11);
      tick();
      wr(0, 4, 8'h44);
      tick();
      clr_in();
      fill_req = 1'b1; fill_first = 8'd3;
      fill_last = 8'd1; fill_data = 8'hA5;
      tick();
      fill_req = 1'b0;
      chk("fill_busy", busy, 1'b1);
      tick();
      rd(0, 3);
      tick();
      chk("fill3_first", rd_data, 8'hA5);
      rd(0, 1);
      tick();
      clr_in();
      chk("fill1_last", rd_data, IV);
      chk("fill_done", busy, 1'b0);
      for (int i = 0; i < 5; i++) begin
         rd(0, i);
         tick();
         chk($sformatf("fill_e%0d", i), rd_data, ex5[i]);
      end
      clr_in();

      rd(13, 0);
      tick();
      clr_in();
      chk("oob_rv", rd_valid, 1'b1);
      chk("oob_rd", rd_data, 8'h00);
      chk("oob_err", addr_err, 1'b1);
      tick();
      chk("oob_err_once", addr_err, 1'b0);
      wr(13, 0, 8'hFF);
      tick();
      clr_in();
      chk("oob_wr_err", addr_err, 1'b1);
      rd(1, 0);
      tick();
      clr_in();
      chk("oob_alias", rd_data, IV);
      fill_req = 1'b1; fill_first = 8'd5;
      fill_last = 8'd200; fill_data = 8'hEE;
      tick();
      fill_req = 1'b0;
      chk("fill_oob_err", addr_err, 1'b1);
      chk("fill_oob_busy", busy, 1'b0);
      for (int i = 0; i < N; i++) begin
         rd(i / C, i % C);
         tick();
      end
      clr_in();

      for (int k = 0; k < 4000; k++) begin
         if (!rst_n) rst_n = 1'b1;
         else if ($urandom_range(0, 599) == 0) rst_n = 1'b0;
         rd_en = 1'($urandom % 2);
         rd_row = 4'(($urandom % 8 == 0) ?
                     12 + $urandom % 4 : $urandom % 12);
         rd_col = 4'($urandom);
         wr_en = ($urandom % 3 == 0);
         wr_row = 4'(($urandom % 8 == 0) ?
                     12 + $urandom % 4 : $urandom % 12);
         wr_col = 4'($urandom);
         wr_data = 8'($urandom);
         fill_req = ($urandom % 12 == 0);
         ff = ($urandom % 10 == 0) ?
              192 + $urandom % 64 : $urandom % 192;
         sp = $urandom % 12;
         lf = ($urandom % 2 == 0) ? ff + sp : ff - sp;
         if (lf < 0) lf = 0;
         fill_first = 8'(ff);
         fill_last = 8'(lf);
         fill_data = 8'($urandom);
         tick();
      end
      clr_in();
      rst_n = 1'b1;
      for (int k = 0; k < 300 && busy; k++) tick();
      chk("drain", busy, 1'b0);

`ifdef TILE_MEM_2D_PARITY_EN
      chk_on = 1'b0;
      tick();
      dut.u_arr.r_mem[0][0] = ~dut.u_arr.r_mem[0][0];
      rd(0, 0);
      tick();
      clr_in();
      chk("perr_v", rd_valid, 1'b1);
      chk("perr", rd_perr, 1'b1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/tile_mem_2d.md
TILE_MEM_2D -- requirements
Module: tile_mem_2d

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning entry width in bits.
REQ-002 SHALL have parameter ROWS, default 16, meaning row count (>=2, any value).
REQ-003 SHALL have parameter COLS, default 16, meaning column count (>=2, any value).
REQ-004 SHALL have parameter INIT_VAL, default 0, meaning value written by the auto-clear sequence.
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 wr_en / wr_row / wr_col / wr_data  in  1 / RW / CW / DATA_W  single-cycle write request; RW=$clog2(ROWS), CW=$clog2(COLS).
REQ-008 rd_en / rd_row / rd_col  in  1 / RW / CW  single-cycle read request.
REQ-009 rd_data / rd_valid  out  DATA_W / 1  read result and its qualifier.
REQ-010 fill_req / fill_first / fill_last / fill_data  in  1 / IW / IW / DATA_W  range-fill command on linear index row*COLS+col; IW=$clog2(ROWS*COLS).
REQ-011 busy  out  1  clear or fill sequence in progress.
REQ-012 addr_err  out  1  one-cycle pulse on an out-of-range access.
REQ-013 rd_perr  out  1  parity error qualifier for rd_data.

Function
REQ-014 SHALL use a state machine with states CLEAR, IDLE and FILL.
REQ-015 CLEAR SHALL write INIT_VAL to one entry per cycle in ascending linear order 0..ROWS*COLS-1, then go to IDLE; duration exactly ROWS*COLS cycles.
REQ-016 In IDLE, fill_req SHALL be accepted and the block SHALL enter FILL on the next cycle; fill_req while busy SHALL be ignored.
REQ-017 FILL SHALL write fill_data (captured at acceptance) to one entry per cycle from fill_first to fill_last inclusive, ascending if first<=last, descending if first>last, then return to IDLE.
REQ-018 A fill with first==last SHALL write exactly one entry and take one cycle in FILL.
REQ-019 A fill index >= ROWS*COLS SHALL cause the command to be rejected with an addr_err pulse and no writes.
REQ-020 busy SHALL be 1 in CLEAR and FILL, 0 in IDLE.
REQ-021 wr_en SHALL update the entry at the next edge when busy=0; wr_en while busy=1 SHALL be dropped with no error.
REQ-022 rd_en SHALL produce rd_data and rd_valid=1 exactly one cycle later; rd_valid SHALL be 0 otherwise, and rd_data SHALL hold its last value.
REQ-023 Reads SHALL be served in all states and return current contents.
REQ-024 A read and a write to the same entry in the same cycle SHALL return the old data (read-first).
REQ-025 Row >= ROWS or col >= COLS SHALL: ignore the write, return rd_data=0 with rd_valid=1 for a read, and pulse addr_err in the following cycle.
REQ-026 Simultaneous wr_en and fill_req in IDLE SHALL perform the write and accept the fill.

Reset
REQ-027 While rst_n=0: rd_data=0, rd_valid=0, addr_err=0, rd_perr=0, busy=0, and the state SHALL be held at CLEAR with its index at 0.
REQ-028 On the first edge with rst_n=1, CLEAR SHALL start; storage SHALL have no reset of its own.
REQ-029 Reset asserted mid-FILL or mid-CLEAR SHALL abort the sequence; a full CLEAR SHALL follow release.

Configuration
REQ-030 Macro TILE_MEM_2D_PARITY_EN SHALL, when defined, store one even-parity bit per entry (written with all data paths) and drive rd_perr=1 with rd_valid if the stored parity mismatches rd_data.
REQ-031 Without TILE_MEM_2D_PARITY_EN, no parity storage SHALL exist and rd_perr SHALL be tied 0.

Structure
REQ-032 Shared package tile_mem_pkg SHALL hold the state enum (CLEAR, IDLE, FILL) and a function computing the linear index from (row, col, COLS).
REQ-033 The storage array SHALL be a sub-module tile_mem_2d_array: one write port, one read port, registered read, read-first.

Verification
REQ-034 Release reset with defaults -> busy=1 for exactly 256 cycles; a read of (15,15) afterwards -> 8'h00.
REQ-035 Fill first=3, last=1, data=8'hA5 -> entries 3, 2, 1 are written in that order over 3 cycles; entries 0 and 4 are unchanged.
REQ-036 Write (2,5)=8'h3C and read (2,5) in the same cycle -> old value; a read in the next cycle -> 8'h3C with rd_valid one cycle later.
REQ-037 ROWS=12: read (13,0) -> rd_data=0 and rd_valid=1, addr_err pulses once; a write to (13,0) -> no entry changes.
REQ-038 Assert rst_n=0 in the middle of a fill of 0..200 -> after release, busy is held for the full CLEAR and all entries read INIT_VAL.
REQ-039 With TILE_MEM_2D_PARITY_EN, force-flip one stored data bit and read that entry -> rd_perr=1 together with rd_valid.
